// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_C = 32;
  localparam int PASOS  = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } estado_e;

  // Two's-complement absolute value when the operand is treated as negative.
  function automatic logic [XLEN_C-1:0] magnitud(input logic [XLEN_C-1:0] v, input logic neg);
    return neg ? (~v + XLEN_C'(1)) : v;
  endfunction

endpackage

// File: rtl/unidad_muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface unidad_muldiv_if;
  import muldiv_pkg::*;

  logic              start;
  logic [2:0]        funct3;
  logic [XLEN_C-1:0] opA;
  logic [XLEN_C-1:0] opB;
  logic [4:0]        rdIn;
  logic              kill;
  logic              busy;
  logic              done;
  logic [XLEN_C-1:0] result;
  logic [4:0]        rdOut;

  modport master (output start, funct3, opA, opB, rdIn, kill,
                  input  busy, done, result, rdOut);
  modport slave  (input  start, funct3, opA, opB, rdIn, kill,
                  output busy, done, result, rdOut);
endinterface

// File: rtl/muldiv_paso.sv
// One iteration of shift-add multiply or restoring divide on the shared 64-bit accumulator.
module muldiv_paso
  import muldiv_pkg::*;
(
  input  logic                  esDiv,
  input  logic [2*XLEN_C-1:0]   acc,
  input  logic [XLEN_C-1:0]     mag,
  output logic [2*XLEN_C-1:0]   accSig
);

  logic [XLEN_C:0]   suma;
  logic [XLEN_C:0]   remDesp;
  logic [XLEN_C-1:0] resta;
  logic              cabe;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    suma    = {1'b0, acc[2*XLEN_C-1:XLEN_C]} + (acc[0] ? {1'b0, mag} : '0);
    remDesp = acc[2*XLEN_C-1:XLEN_C-1];
    cabe    = remDesp >= {1'b0, mag};
    // The true difference is below the divisor, so 32 bits hold it exactly.
    resta   = remDesp[XLEN_C-1:0] - mag;
    accSig  = {suma, acc[XLEN_C-1:1]};
    if (esDiv) begin
      if (cabe) accSig = {resta, acc[XLEN_C-2:0], 1'b1};
      else      accSig = {remDesp[XLEN_C-1:0], acc[XLEN_C-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, operand conditioning and sign/override fix-up.
module unidad_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_C
)
(
  input  logic            CLK,
  input  logic            RST_n,
  unidad_muldiv_if.slave  bus
);

  estado_e           estado, estadoSig;
  logic [4:0]        cnt;
  funct3_e           op;
  logic [4:0]        rdReg;
  logic [2*XLEN-1:0] acc, accPaso, accNeg;
  logic [XLEN-1:0]   mag, opAOrig;
  logic              signRes, divZero, ovf;
  logic [XLEN-1:0]   resultReg, resFix, remNeg, quotNeg;
  logic [4:0]        rdOutReg;
  funct3_e           f3In;
  logic              sgnA, sgnB;
  logic [XLEN-1:0]   magA, magB;

  muldiv_paso u_paso (
    .esDiv  (op inside {DIV, DIVU, REM, REMU}),
    .acc    (acc),
    .mag    (mag),
    .accSig (accPaso)
  );

  always_comb begin
    f3In = funct3_e'(bus.funct3);
    sgnA = (f3In inside {MUL, MULH, MULHSU, DIV, REM}) && bus.opA[XLEN-1];
    sgnB = (f3In inside {MUL, MULH, DIV, REM}) && bus.opB[XLEN-1];
    magA = magnitud(bus.opA, sgnA);
    magB = magnitud(bus.opB, sgnB);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) estado <= IDLE;
    else        estado <= estadoSig;
  end

  always_comb begin
    estadoSig = estado;
    case (estado)
      IDLE:    if (bus.start) estadoSig = CALC;
      CALC:    if (cnt == 5'(PASOS - 1)) estadoSig = FIX;
      FIX:     estadoSig = DONE;
      DONE:    estadoSig = IDLE;
      default: estadoSig = IDLE;
    endcase
    if (bus.kill) estadoSig = IDLE;
  end

  // Overrides for divide-by-zero and signed overflow win over sign correction.
  always_comb begin
    accNeg  = ~acc + (2*XLEN)'(1);
    quotNeg = ~acc[XLEN-1:0] + XLEN'(1);
    remNeg  = ~acc[2*XLEN-1:XLEN] + XLEN'(1);
    resFix  = '0;
    case (op)
      MUL:                resFix = signRes ? accNeg[XLEN-1:0] : acc[XLEN-1:0];
      MULH, MULHSU, MULHU: resFix = signRes ? accNeg[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (divZero)  resFix = '1;
        else if (ovf) resFix = {1'b1, {(XLEN-1){1'b0}}};
        else          resFix = signRes ? quotNeg : acc[XLEN-1:0];
      end
      default: begin
        if (divZero)  resFix = opAOrig;
        else if (ovf) resFix = '0;
        else          resFix = signRes ? remNeg : acc[2*XLEN-1:XLEN];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt       <= '0;
      op        <= MUL;
      rdReg     <= '0;
      acc       <= '0;
      mag       <= '0;
      opAOrig   <= '0;
      signRes   <= 1'b0;
      divZero   <= 1'b0;
      ovf       <= 1'b0;
      resultReg <= '0;
      rdOutReg  <= '0;
    end else if (!bus.kill) begin
      case (estado)
        IDLE: if (bus.start) begin
          op      <= f3In;
          rdReg   <= bus.rdIn;
          opAOrig <= bus.opA;
          cnt     <= '0;
          signRes <= (f3In inside {REM, REMU}) ? sgnA : (sgnA ^ sgnB);
          divZero <= (bus.opB == '0);
          ovf     <= (f3In inside {DIV, REM}) && (bus.opA == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.opB == '1);
          // Multiply walks the multiplier (opB) through the low word; divide shifts the dividend out.
          if (f3In inside {DIV, DIVU, REM, REMU}) begin
            acc <= {{XLEN{1'b0}}, magA};
            mag <= magB;
          end else begin
            acc <= {{XLEN{1'b0}}, magB};
            mag <= magA;
          end
        end
        CALC: begin
          acc <= accPaso;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          resultReg <= resFix;
          rdOutReg  <= rdReg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (estado == CALC) || (estado == FIX);
  assign bus.done   = (estado == DONE);
  assign bus.result = resultReg;
  assign bus.rdOut  = rdOutReg;

endmodule
